// File: rtl/fft_fifo_pkg.sv
// Shared types and defaults for the FFT inter-stage FIFO.
// A sample is one complex word: 20-bit I in the upper half, 20-bit Q in the lower half.
package fft_fifo_pkg;

  localparam int FIFO_DATA_W = 40;
  localparam int FIFO_ADDR_W = 9;

  localparam bit FIFO_STD  = 1'b0;
  localparam bit FIFO_FWFT = 1'b1;

  typedef struct packed {
    logic [19:0] i;
    logic [19:0] q;
  } sample_t;

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// Written so that synthesis maps it onto block RAM.
module fifo_sdp_ram #(
  parameter int DATA_W = 40,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_sync_fifo.sv
// Parametrised single-clock FIFO between FFT stages, with standard or FWFT read mode.
// In FWFT mode the RAM read register itself acts as the prefetched output stage.
module fft_sync_fifo
  import fft_fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AF_THRESH = 508,
  parameter int AE_THRESH = 4,
  parameter bit FWFT      = FIFO_STD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   data_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] ZERO_C  = '0;

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic              out_vld_q, out_vld_d;
  logic              dout_seen_q;
  logic              full_q, empty_q, empty_d, af_q, ae_q;
  logic              valid_q, ovf_q, unf_q;
  logic              wr_ok, rd_ok, ram_rd;
  logic [DATA_W-1:0] ram_q;

  // Acceptance is judged only on the registered flags, never on a same-cycle push/pop.
  always_comb begin
    wr_ok     = wr_en & ~full_q;
    rd_ok     = rd_en & ~empty_q;
    count_d   = count_q + {{ADDR_W{1'b0}}, wr_ok} - {{ADDR_W{1'b0}}, rd_ok};
    ram_rd    = 1'b0;
    ram_cnt_d = ram_cnt_q;
    out_vld_d = 1'b0;
    empty_d   = 1'b1;
    if (FWFT) begin
      // Refill the output stage whenever it is empty or being popped this cycle.
      ram_rd    = (ram_cnt_q != ZERO_C) && (!out_vld_q || rd_ok);
      out_vld_d = ram_rd | (out_vld_q & ~rd_ok);
      ram_cnt_d = ram_cnt_q + {{ADDR_W{1'b0}}, wr_ok} - {{ADDR_W{1'b0}}, ram_rd};
      empty_d   = ~out_vld_d;
    end else begin
      ram_rd    = rd_ok;
      ram_cnt_d = count_d;
      empty_d   = (count_d == ZERO_C);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ram_cnt_q   <= '0;
      out_vld_q   <= 1'b0;
      dout_seen_q <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      if (wr_ok)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (ram_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (ram_rd) dout_seen_q <= 1'b1;
      count_q   <= count_d;
      ram_cnt_q <= ram_cnt_d;
      out_vld_q <= out_vld_d;
      full_q    <= (count_d == DEPTH_C);
      empty_q   <= empty_d;
      af_q      <= (count_d >= AF_C);
      ae_q      <= (count_d <= AE_C);
      valid_q   <= rd_ok;
      ovf_q     <= wr_en & full_q;
      unf_q     <= rd_en & empty_q;
    end
  end

  fifo_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_q)
  );

  // RAM output is not reset, so dout reads as zero until the first word is fetched.
  assign dout         = dout_seen_q ? ram_q : '0;
  assign valid        = FWFT ? out_vld_q : valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign data_count   = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
